fp64_mul_prestage: RTL

- Two-stage pipelined operand front end of the double-precision multiplier.
- Unpacks two IEEE-754 binary64 operands and classifies each as zero, Inf, NaN or normal; the exponent-field and mantissa all-zero checks are NOR-reduction trees.
- Forwards sign, biased exponent sum and hidden-bit mantissas to the Vedic mantissa multiplier.
- Resolves special-case results early so the downstream datapath can bypass them.
- Valid/ready handshake on both sides, with full backpressure.

---
 rtl/fp64_mul_prestage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fp64_mul_prestage.sv
// fp64_mul_prestage: two-stage operand front end of the binary64 multiplier.
// Classifies both operands, forms sign / exponent sum / hidden-bit mantissas and resolves special results.
module fp64_mul_prestage #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52,
    parameter int unsigned BIAS  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign_out,
    output logic [EXP_W+1:0]     exp_sum,
    output logic [MAN_W:0]       man_a,
    output logic [MAN_W:0]       man_b,
    output logic                 is_special,
    output logic [EXP_W+MAN_W:0] special_result,
    output logic                 invalid_flag
);

    localparam int unsigned DW = EXP_W + MAN_W + 1;
    localparam int unsigned SW = EXP_W + 2;
    localparam logic [DW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Pipeline occupancy and handshake
    logic v1;
    logic v2;
    logic adv1;
    logic adv2;
    logic load1;
    logic load2;

    always_comb begin
        adv2  = ~v2 | out_ready;
        adv1  = ~v1 | adv2;
        load1 = in_valid & adv1;
        load2 = v1 & adv2;
    end

    assign in_ready  = adv1;
    assign out_valid = v2;

    // Operand field extraction and classification (NOR-reduction all-zero detectors)
    logic             sgn_fa;
    logic             sgn_fb;
    logic [EXP_W-1:0] exp_fa;
    logic [EXP_W-1:0] exp_fb;
    logic [MAN_W-1:0] man_fa;
    logic [MAN_W-1:0] man_fb;
    logic             ez_a;
    logic             eo_a;
    logic             mz_a;
    logic             ez_b;
    logic             eo_b;
    logic             mz_b;
    logic             zero_a_c;
    logic             inf_a_c;
    logic             nan_a_c;
    logic             snan_a_c;
    logic             zero_b_c;
    logic             inf_b_c;
    logic             nan_b_c;
    logic             snan_b_c;

    always_comb begin
        sgn_fa   = a[DW-1];
        sgn_fb   = b[DW-1];
        exp_fa   = a[DW-2:MAN_W];
        exp_fb   = b[DW-2:MAN_W];
        man_fa   = a[MAN_W-1:0];
        man_fb   = b[MAN_W-1:0];
        ez_a     = ~|exp_fa;
        eo_a     = &exp_fa;
        mz_a     = ~|man_fa;
        ez_b     = ~|exp_fb;
        eo_b     = &exp_fb;
        mz_b     = ~|man_fb;
        // Denormals are flushed to zero
        zero_a_c = ez_a;
        inf_a_c  = eo_a & mz_a;
        nan_a_c  = eo_a & ~mz_a;
        snan_a_c = nan_a_c & ~man_fa[MAN_W-1];
        zero_b_c = ez_b;
        inf_b_c  = eo_b & mz_b;
        nan_b_c  = eo_b & ~mz_b;
        snan_b_c = nan_b_c & ~man_fb[MAN_W-1];
    end

    // Stage 1 registers
    logic             s1_sign_a;
    logic             s1_sign_b;
    logic [EXP_W-1:0] s1_exp_a;
    logic [EXP_W-1:0] s1_exp_b;
    logic [MAN_W-1:0] s1_man_a;
    logic [MAN_W-1:0] s1_man_b;
    logic             s1_zero_a;
    logic             s1_inf_a;
    logic             s1_nan_a;
    logic             s1_snan_a;
    logic             s1_zero_b;
    logic             s1_inf_b;
    logic             s1_nan_b;
    logic             s1_snan_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_exp_a  <= '0;
            s1_exp_b  <= '0;
            s1_man_a  <= '0;
            s1_man_b  <= '0;
            s1_zero_a <= 1'b0;
            s1_inf_a  <= 1'b0;
            s1_nan_a  <= 1'b0;
            s1_snan_a <= 1'b0;
            s1_zero_b <= 1'b0;
            s1_inf_b  <= 1'b0;
            s1_nan_b  <= 1'b0;
            s1_snan_b <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
            end
            if (load1) begin
                s1_sign_a <= sgn_fa;
                s1_sign_b <= sgn_fb;
                s1_exp_a  <= exp_fa;
                s1_exp_b  <= exp_fb;
                s1_man_a  <= man_fa;
                s1_man_b  <= man_fb;
                s1_zero_a <= zero_a_c;
                s1_inf_a  <= inf_a_c;
                s1_nan_a  <= nan_a_c;
                s1_snan_a <= snan_a_c;
                s1_zero_b <= zero_b_c;
                s1_inf_b  <= inf_b_c;
                s1_nan_b  <= nan_b_c;
                s1_snan_b <= snan_b_c;
            end
        end
    end

    // Stage 2 bundle formation and special-case priority resolution
    logic            sign_c;
    logic [SW-1:0]   exp_c;
    logic [MAN_W:0]  man_a_c;
    logic [MAN_W:0]  man_b_c;
    logic            special_c;
    logic [DW-1:0]   result_c;
    logic            invalid_c;

    always_comb begin
        sign_c    = s1_sign_a ^ s1_sign_b;
        exp_c     = SW'(s1_exp_a) + SW'(s1_exp_b) - SW'(BIAS);
        man_a_c   = s1_zero_a ? '0 : {1'b1, s1_man_a};
        man_b_c   = s1_zero_b ? '0 : {1'b1, s1_man_b};
        special_c = 1'b0;
        result_c  = '0;
        invalid_c = 1'b0;
        if (s1_nan_a | s1_nan_b) begin
            special_c = 1'b1;
            result_c  = QNAN;
            invalid_c = s1_snan_a | s1_snan_b;
        end else if ((s1_inf_a & s1_zero_b) | (s1_zero_a & s1_inf_b)) begin
            special_c = 1'b1;
            result_c  = QNAN;
            invalid_c = 1'b1;
        end else if (s1_inf_a | s1_inf_b) begin
            special_c = 1'b1;
            result_c  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_zero_a | s1_zero_b) begin
            special_c = 1'b1;
            result_c  = {sign_c, {(DW-1){1'b0}}};
        end
    end

    // Stage 2 output registers; hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2             <= 1'b0;
            sign_out       <= 1'b0;
            exp_sum        <= '0;
            man_a          <= '0;
            man_b          <= '0;
            is_special     <= 1'b0;
            special_result <= '0;
            invalid_flag   <= 1'b0;
        end else begin
            if (adv2) begin
                v2 <= v1;
            end
            if (load2) begin
                sign_out       <= sign_c;
                exp_sum        <= exp_c;
                man_a          <= man_a_c;
                man_b          <= man_b_c;
                is_special     <= special_c;
                special_result <= result_c;
                invalid_flag   <= invalid_c;
            end
        end
    end

endmodule
